// File: rtl/tdc_hw_stats_pkg.sv
// Shared types and width helpers for the TDC Hamming-weight statistics block.
package tdc_stats_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_READOUT = 2'd2
   } state_t;

   // Readout position: sum bytes, then min, then max (up to 16 bytes total).
   typedef logic [3:0] byte_idx_t;

   function automatic int calc_sum_w(input int hw_w, input int log2_samples);
      return hw_w + log2_samples;
   endfunction

   function automatic int calc_n_sum_bytes(input int sum_w);
      return (sum_w + 7) / 8;
   endfunction

endpackage

// File: rtl/tdc_hw_stats_val_sync.sv
// Synchronises the asynchronous TDC valid strobe into clk and emits a
// one-cycle registered pulse on each rising edge.
module tdc_val_sync #(
   parameter int N_SYNC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic val_in,
   output logic edge_pulse
);

   logic [N_SYNC-1:0] sync_r;
   logic              sync_d_r;
   logic              pulse_r;

   // Synchroniser chain, delayed copy and registered rising-edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r   <= '0;
         sync_d_r <= 1'b0;
         pulse_r  <= 1'b0;
      end else begin
         sync_r   <= {sync_r[N_SYNC-2:0], val_in};
         sync_d_r <= sync_r[N_SYNC-1];
         pulse_r  <= sync_r[N_SYNC-1] & ~sync_d_r;
      end
   end

   assign edge_pulse = pulse_r;

endmodule

// File: rtl/tdc_hw_stats.sv
// Batch statistics (sum/min/max/mean) over TDC Hamming-weight samples with a
// bytewise valid/ready readout of sum (LSB first), min and max.
module tdc_hw_stats
   import tdc_stats_pkg::*;
#(
   parameter int HW_W         = 7,
   parameter int LOG2_SAMPLES = 8,
   parameter int N_SYNC       = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            start,
   input  logic [HW_W-1:0] hw_in,
   input  logic            val_in,
   output logic            busy,
   output logic            overrun,
   output logic [HW_W-1:0] mean,
   output logic [7:0]      rd_data,
   output logic            rd_valid,
   input  logic            rd_ready
);

   localparam int SUM_W       = calc_sum_w(HW_W, LOG2_SAMPLES);
   localparam int N_SUM_BYTES = calc_n_sum_bytes(SUM_W);
   localparam int SUM_PAD_W   = 8 * N_SUM_BYTES;
   localparam byte_idx_t              LAST_IDX = byte_idx_t'(N_SUM_BYTES + 1);
   localparam logic [LOG2_SAMPLES:0]  LAST_CNT = (LOG2_SAMPLES+1)'((1 << LOG2_SAMPLES) - 1);

   state_t                state_r, state_nxt_s;
   logic                  edge_s, edge_en_s;
   logic                  start_acc_s, last_pulse_s, hs_s, last_hs_s;
   logic [SUM_W-1:0]      sum_r, sum_add_s;
   logic [HW_W-1:0]       min_r, min_nxt_s, max_r, max_nxt_s;
   logic [LOG2_SAMPLES:0] count_r;
   byte_idx_t             idx_r;
   logic                  started_r;
   logic                  busy_r, busy_nxt_s, overrun_r, overrun_nxt_s;
   logic [HW_W-1:0]       mean_r;
   logic [7:0]            rd_data_r;
   logic                  rd_valid_r;

   function automatic logic [7:0] sel_byte(input byte_idx_t idx, input logic [SUM_W-1:0] s,
                                           input logic [HW_W-1:0] mn, input logic [HW_W-1:0] mx);
      logic [SUM_PAD_W-1:0] pad;
      logic [7:0]           r;
      pad          = '0;
      pad[SUM_W-1:0] = s;
      r            = 8'h00;
      for (int b = 0; b < N_SUM_BYTES; b++) begin
         if (idx == byte_idx_t'(b)) r = pad[8*b +: 8];
      end
      if (idx == byte_idx_t'(N_SUM_BYTES)) begin
         r            = 8'h00;
         r[HW_W-1:0]  = mn;
      end else if (idx == LAST_IDX) begin
         r            = 8'h00;
         r[HW_W-1:0]  = mx;
      end else begin
         r = r;
      end
      return r;
   endfunction

   tdc_val_sync #(.N_SYNC(N_SYNC)) u_val_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .val_in     (val_in),
      .edge_pulse (edge_s)
   );

   assign edge_en_s    = edge_s & en;
   assign start_acc_s  = (state_r == ST_IDLE) && start && en;
   assign last_pulse_s = (state_r == ST_ACCUM) && edge_en_s && (count_r == LAST_CNT);
   assign hs_s         = rd_valid_r && rd_ready;
   assign last_hs_s    = (state_r == ST_READOUT) && hs_s && (idx_r == LAST_IDX);
   assign sum_add_s    = sum_r + SUM_W'(hw_in);
   assign min_nxt_s    = (hw_in < min_r) ? hw_in : min_r;
   assign max_nxt_s    = (hw_in > max_r) ? hw_in : max_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    if (start_acc_s)  state_nxt_s = ST_ACCUM;   else state_nxt_s = ST_IDLE;
         ST_ACCUM:   if (last_pulse_s) state_nxt_s = ST_READOUT; else state_nxt_s = ST_ACCUM;
         ST_READOUT: if (last_hs_s)    state_nxt_s = ST_IDLE;    else state_nxt_s = ST_READOUT;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; IDLE pulses only count as overrun once a batch has been started.
   always_comb begin
      busy_nxt_s    = (state_nxt_s != ST_IDLE);
      overrun_nxt_s = overrun_r;
      if (start_acc_s) begin
         overrun_nxt_s = 1'b0;
      end else if (edge_en_s && ((state_r == ST_READOUT) || ((state_r == ST_IDLE) && started_r))) begin
         overrun_nxt_s = 1'b1;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // Accumulator, readout sequencing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r      <= '0;
         min_r      <= '1;
         max_r      <= '0;
         count_r    <= '0;
         idx_r      <= '0;
         started_r  <= 1'b0;
         busy_r     <= 1'b0;
         overrun_r  <= 1'b0;
         mean_r     <= '0;
         rd_data_r  <= 8'h00;
         rd_valid_r <= 1'b0;
      end else begin
         busy_r    <= busy_nxt_s;
         overrun_r <= overrun_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (start_acc_s) begin
                  sum_r     <= '0;
                  min_r     <= '1;
                  max_r     <= '0;
                  count_r   <= '0;
                  idx_r     <= '0;
                  started_r <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (edge_en_s) begin
                  sum_r   <= sum_add_s;
                  min_r   <= min_nxt_s;
                  max_r   <= max_nxt_s;
                  count_r <= count_r + (LOG2_SAMPLES+1)'(1);
                  if (last_pulse_s) begin
                     mean_r     <= sum_add_s[SUM_W-1:LOG2_SAMPLES];
                     rd_valid_r <= 1'b1;
                     rd_data_r  <= sel_byte(byte_idx_t'(0), sum_add_s, min_nxt_s, max_nxt_s);
                  end
               end
            end
            ST_READOUT: begin
               if (hs_s) begin
                  if (idx_r == LAST_IDX) begin
                     rd_valid_r <= 1'b0;
                     rd_data_r  <= 8'h00;
                     idx_r      <= '0;
                  end else begin
                     idx_r     <= idx_r + byte_idx_t'(1);
                     rd_data_r <= sel_byte(idx_r + byte_idx_t'(1), sum_r, min_r, max_r);
                  end
               end
            end
            default: begin
               rd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign overrun  = overrun_r;
   assign mean     = mean_r;
   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_tdc_hw_stats.sv
// Scoreboard bench: two instances (batch of 4 and batch of 256), expected
// readout bytes queued at stimulus time and popped by per-instance monitors.
module tb_tdc_hw_stats;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_a, start_a, val_a, rd_ready_a;
   logic [6:0] hw_a;
   logic       busy_a, overrun_a, rd_valid_a;
   logic [6:0] mean_a;
   logic [7:0] rd_data_a;
   logic       en_b, start_b, val_b, rd_ready_b;
   logic [6:0] hw_b;
   logic       busy_b, overrun_b, rd_valid_b;
   logic [6:0] mean_b;
   logic [7:0] rd_data_b;

   int checks = 0;
   int errors = 0;
   int mode_a = 0;   // 0: ready always, 1: ready 1-of-3 cycles, 2: ready held low
   logic [7:0] exp_q_a[$];
   logic [7:0] exp_q_b[$];

   always #5 clk = ~clk;

   tdc_hw_stats #(.HW_W(7), .LOG2_SAMPLES(2), .N_SYNC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .start(start_a), .hw_in(hw_a), .val_in(val_a),
      .busy(busy_a), .overrun(overrun_a), .mean(mean_a), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .rd_ready(rd_ready_a));

   tdc_hw_stats #(.HW_W(7), .LOG2_SAMPLES(8), .N_SYNC(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .start(start_b), .hw_in(hw_b), .val_in(val_b),
      .busy(busy_b), .overrun(overrun_b), .mean(mean_b), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .rd_ready(rd_ready_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Tasks start and end at posedge+1.
   task automatic send(input int sel, input logic [6:0] hw, input logic en_v);
      if (sel == 0) begin hw_a = hw; en_a = en_v; val_a = 1'b1; end
      else          begin hw_b = hw; en_b = en_v; val_b = 1'b1; end
      repeat (5) @(posedge clk);
      #1;
      if (sel == 0) val_a = 1'b0; else val_b = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
   endtask

   task automatic do_start(input int sel);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk);
      #1;
      if (sel == 0) start_a = 1'b0; else start_b = 1'b0;
   endtask

   task automatic push_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      exp_q_a.push_back(b0); exp_q_a.push_back(b1); exp_q_a.push_back(b2); exp_q_a.push_back(b3);
   endtask

   task automatic wait_idle(input int sel, input int budget, input string name);
      int n;
      n = 0;
      while (((sel == 0) ? busy_a : busy_b) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_idle_timeout"}, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
   endtask

   // Ready driver for instance A.
   initial begin
      int cnt;
      cnt = 0;
      rd_ready_a = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cnt++;
         case (mode_a)
            1:       rd_ready_a = ((cnt % 3) == 0);
            2:       rd_ready_a = 1'b0;
            default: rd_ready_a = 1'b1;
         endcase
      end
   end

   // Monitor A: byte order, hold stability while stalled, idle after last byte.
   initial begin
      logic       hold, last;
      logic [7:0] held, e;
      hold = 1'b0; last = 1'b0; held = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0; last = 1'b0;
         end else begin
            if (hold) check("a_hold_stable", {23'd0, rd_valid_a, rd_data_a}, {23'd0, 1'b1, held});
            if (last) check("a_idle_after_last", {busy_a, rd_valid_a}, 2'b00);
            last = 1'b0;
            if (rd_valid_a && rd_ready_a) begin
               if (exp_q_a.size() == 0) begin
                  check("a_unexpected_byte", rd_data_a, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q_a.pop_front();
                  check("a_byte", rd_data_a, e);
                  last = (exp_q_a.size() == 0);
               end
            end
            hold = rd_valid_a && !rd_ready_a;
            held = rd_data_a;
         end
      end
   end

   // Monitor B: always ready.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid_b && rd_ready_b) begin
            if (exp_q_b.size() == 0) begin
               check("b_unexpected_byte", rd_data_b, 32'hFFFF_FFFF);
            end else begin
               e = exp_q_b.pop_front();
               check("b_byte", rd_data_b, e);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en_a = 1'b1; start_a = 1'b0; val_a = 1'b0; hw_a = 7'd0;
      en_b = 1'b1; start_b = 1'b0; val_b = 1'b0; hw_b = 7'd0; rd_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy_a, 32'd0);
      check("rst_overrun", overrun_a, 32'd0);
      check("rst_rd_valid", rd_valid_a, 32'd0);
      check("rst_mean", mean_a, 32'd0);
      check("rst_rd_data", rd_data_a, 32'd0);
      check("rst_busy_b", busy_b, 32'd0);
      @(posedge clk);
      #1;

      // Pulse before any start must not flag overrun.
      send(0, 7'd5, 1'b1);
      check("ovr_before_start", overrun_a, 32'd0);

      // Basic batch 10,20,30,40.
      push_a(8'd100, 8'd0, 8'd10, 8'd40);
      do_start(0);
      check("t1_busy", busy_a, 32'd1);
      send(0, 7'd10, 1'b1); send(0, 7'd20, 1'b1); send(0, 7'd30, 1'b1); send(0, 7'd40, 1'b1);
      wait_idle(0, 100, "t1");
      check("t1_mean", mean_a, 32'd25);
      check("t1_overrun", overrun_a, 32'd0);

      // Pulse in IDLE after a batch.
      send(0, 7'd3, 1'b1);
      check("ovr_idle", overrun_a, 32'd1);

      // Same batch with slow consumer.
      mode_a = 1;
      push_a(8'd100, 8'd0, 8'd10, 8'd40);
      do_start(0);
      check("t2_ovr_cleared", overrun_a, 32'd0);
      send(0, 7'd10, 1'b1); send(0, 7'd20, 1'b1); send(0, 7'd30, 1'b1); send(0, 7'd40, 1'b1);
      wait_idle(0, 200, "t2");
      check("t2_mean", mean_a, 32'd25);

      // Stalled readout with a pulse arriving during READOUT.
      mode_a = 2;
      push_a(8'd100, 8'd0, 8'd10, 8'd40);
      do_start(0);
      send(0, 7'd10, 1'b1); send(0, 7'd20, 1'b1); send(0, 7'd30, 1'b1); send(0, 7'd40, 1'b1);
      @(negedge clk);
      check("t3_valid_stalled", rd_valid_a, 32'd1);
      check("t3_busy_stalled", busy_a, 32'd1);
      @(posedge clk);
      #1;
      send(0, 7'd9, 1'b1);
      check("ovr_readout", overrun_a, 32'd1);
      mode_a = 0;
      wait_idle(0, 100, "t3");
      check("t3_ovr_sticky", overrun_a, 32'd1);

      // en gating: only enabled pulses counted.
      push_a(8'd26, 8'd0, 8'd5, 8'd8);
      do_start(0);
      check("t5_ovr_cleared", overrun_a, 32'd0);
      send(0, 7'd5, 1'b1); send(0, 7'd99, 1'b0); send(0, 7'd6, 1'b1);
      send(0, 7'd77, 1'b0); send(0, 7'd7, 1'b1); send(0, 7'd8, 1'b1);
      wait_idle(0, 100, "t5");
      check("t5_mean", mean_a, 32'd6);
      check("t5_overrun", overrun_a, 32'd0);

      // Full-size batch of 256 samples of 64.
      exp_q_b.push_back(8'h00); exp_q_b.push_back(8'h40);
      exp_q_b.push_back(8'd64); exp_q_b.push_back(8'd64);
      do_start(1);
      for (int i = 0; i < 256; i++) send(1, 7'd64, 1'b1);
      wait_idle(1, 100, "b");
      check("b_mean", mean_b, 32'd64);
      check("b_overrun", overrun_b, 32'd0);
      check("b_queue_empty", exp_q_b.size(), 32'd0);

      // Reset mid-ACCUM, then fresh batch with an ignored start inside ACCUM.
      do_start(0);
      send(0, 7'd50, 1'b1); send(0, 7'd60, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_busy", busy_a, 32'd0);
      check("t6_rst_valid", rd_valid_a, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_a(8'd4, 8'd0, 8'd1, 8'd1);
      do_start(0);
      send(0, 7'd1, 1'b1);
      do_start(0);
      send(0, 7'd1, 1'b1); send(0, 7'd1, 1'b1); send(0, 7'd1, 1'b1);
      wait_idle(0, 100, "t6");
      check("t6_mean", mean_a, 32'd1);
      repeat (3) @(posedge clk);
      check("a_queue_empty", exp_q_a.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
